vga_timing_gen: RTL

- Generates VGA raster timing and sweeps the pixel coordinates `pix_x`/`pix_y` that the combinational grid/glyph renderer consumes.
- Takes the renderer's RGB and `video_on` back in the same cycle and drives the DAC-side VGA pins.
- Sync and blanking are registered in the same stage as the RGB, so pins stay pixel-aligned.
- Sits between the system clock/reset and the top-level VGA pins; one instance per display.

---
 rtl/vga_timing_gen.sv | 122 ++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: sweeps pix_x/pix_y for a combinational renderer and registers
// RGB, sync and blanking in one stage. With CLK_DIV=1 VGA_CLK is held at 0; the DAC must use clk.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned CLK_DIV  = 2
) (
  input  logic       clk,
  input  logic       resetn,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       frame_start,
  input  logic [7:0] vga_R_in,
  input  logic [7:0] vga_G_in,
  input  logic [7:0] vga_B_in,
  input  logic       video_on_in,
  output logic [7:0] VGA_R,
  output logic [7:0] VGA_G,
  output logic [7:0] VGA_B,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic       VGA_SYNC_N,
  output logic       VGA_CLK
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;
  localparam int unsigned DivW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DivW-1:0] div_q, div_d;
  logic [9:0]      h_q, h_d, v_q, v_d;
  logic [7:0]      r_q, r_d, g_q, g_d, b_q, b_d;
  logic            hs_q, hs_d, vs_q, vs_d, blank_n_q, blank_n_d;
  logic            frame_start_q, frame_start_d, vga_clk_q, vga_clk_d;
  logic            tick, h_last, v_last, active, pix_on;

  // For CLK_DIV=1 div_q stays 0, which already equals CLK_DIV-1, so tick is constant 1.
  assign tick   = (div_q == DivW'(CLK_DIV - 1));
  assign h_last = (h_q == 10'(H_TOTAL - 1));
  assign v_last = (v_q == 10'(V_TOTAL - 1));
  assign active = (h_q < 10'(H_ACTIVE)) && (v_q < 10'(V_ACTIVE));
  assign pix_on = active && video_on_in;

  always_comb begin
    div_d         = tick ? '0 : div_q + 1'b1;
    h_d           = h_q;
    v_d           = v_q;
    r_d           = r_q;
    g_d           = g_q;
    b_d           = b_q;
    hs_d          = hs_q;
    vs_d          = vs_q;
    blank_n_d     = blank_n_q;
    frame_start_d = tick && h_last && v_last;
    // Registered from the next divider value so the rising edge lands mid output period.
    vga_clk_d     = (CLK_DIV > 1) && (32'(div_d) >= CLK_DIV / 2);
    if (tick) begin
      h_d = h_last ? 10'd0 : h_q + 10'd1;
      if (h_last) begin
        v_d = v_last ? 10'd0 : v_q + 10'd1;
      end
      blank_n_d = active;
      r_d       = pix_on ? vga_R_in : 8'd0;
      g_d       = pix_on ? vga_G_in : 8'd0;
      b_d       = pix_on ? vga_B_in : 8'd0;
      hs_d      = ~((h_q >= 10'(HS_START)) && (h_q < 10'(HS_END)));
      vs_d      = ~((v_q >= 10'(VS_START)) && (v_q < 10'(VS_END)));
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_q         <= '0;
      h_q           <= '0;
      v_q           <= '0;
      r_q           <= '0;
      g_q           <= '0;
      b_q           <= '0;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      blank_n_q     <= 1'b0;
      frame_start_q <= 1'b0;
      vga_clk_q     <= 1'b0;
    end else begin
      div_q         <= div_d;
      h_q           <= h_d;
      v_q           <= v_d;
      r_q           <= r_d;
      g_q           <= g_d;
      b_q           <= b_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      blank_n_q     <= blank_n_d;
      frame_start_q <= frame_start_d;
      vga_clk_q     <= vga_clk_d;
    end
  end

  assign pix_x       = h_q;
  assign pix_y       = v_q;
  assign frame_start = frame_start_q;
  assign VGA_R       = r_q;
  assign VGA_G       = g_q;
  assign VGA_B       = b_q;
  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign VGA_BLANK_N = blank_n_q;
  assign VGA_SYNC_N  = 1'b0;
  assign VGA_CLK     = vga_clk_q;

endmodule
